serial_adder_ctrl: RTL
======================

SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, operand/sum width in bits; legal range 2..32.
REQ-002 i_clk  input  1  sole clock; all state updates on rising edge.
REQ-003 i_rst  input  1  synchronous, active-high reset.
REQ-004 i_start  input  1  request to begin an addition; sampled only in IDLE.
REQ-005 i_a  input  WIDTH  operand A, captured on the accepting edge.
REQ-006 i_b  input  WIDTH  operand B, captured on the accepting edge.
REQ-007 i_cin  input  1  carry-in, captured on the accepting edge.
REQ-008 o_busy  output  1  high in RUN and DONE.
REQ-009 o_done  output  1  single-cycle pulse; result valid.
REQ-010 o_sum  output  WIDTH  result, held until the next accepted start.
REQ-011 o_cout  output  1  carry-out of bit WIDTH-1, held like o_sum.
REQ-012 o_ovf  output  1  signed overflow; present only per REQ-030.

Function
REQ-013 The block SHALL add A+B+cin bit-serially, one bit per clock, LSB first, using a single 1-bit full-adder cell.
REQ-014 FSM states: IDLE, RUN, DONE.
REQ-015 IDLE: i_start=1 SHALL load A/B shift registers, load the carry flop with i_cin, clear the bit counter, clear o_sum/o_cout(/o_ovf), and go to RUN.
REQ-016 RUN: each edge SHALL feed A[0], B[0] and the carry flop to the cell, shift its sum into o_sum from the MSB end, shift A/B right, store the cell carry, and increment the counter.
REQ-017 RUN SHALL exit to DONE on the edge processing bit WIDTH-1 (counter == WIDTH-1); o_cout SHALL take the final carry on that edge.
REQ-018 DONE: o_done=1 for exactly one cycle, then return to IDLE unconditionally.
REQ-019 Latency: for the accepting edge E, o_done SHALL be high in the cycle after edge E+WIDTH.
REQ-020 i_start SHALL be ignored in RUN and DONE; operand changes there SHALL have no effect.
REQ-021 The earliest next accept SHALL be the edge that ends the IDLE cycle following DONE; throughput is one add per WIDTH+2 cycles.
REQ-022 Counter width SHALL be clog2(WIDTH); there is no counter wrap, because the exit occurs at WIDTH-1.
REQ-023 o_sum SHALL be the modulo 2^WIDTH sum; {o_cout,o_sum} SHALL equal the exact A+B+cin.

Reset
REQ-024 i_rst=1 SHALL force IDLE and clear o_busy, o_done, o_sum, o_cout, o_ovf, the carry flop, the counter and the shift registers to 0.
REQ-025 Reset asserted in any state, including mid-RUN, SHALL abort the operation with no o_done pulse.
REQ-026 i_rst and i_start in the same cycle: reset wins and the start is dropped.
REQ-027 The first start SHALL be accepted on the first edge with i_rst=0.

Configuration
REQ-028 The macro SERIAL_ADDER_OVF_EN SHALL control overflow detection.
REQ-029 Without the macro: there is no o_ovf port and no overflow logic.
REQ-030 With the macro: o_ovf SHALL be registered on the final RUN edge as (carry into bit WIDTH-1) XOR (carry out of bit WIDTH-1), held like o_sum, and cleared per REQ-015/REQ-024.

Structure
REQ-031 A shared package serial_adder_pkg SHALL hold the FSM state typedef (IDLE/RUN/DONE) and the default WIDTH constant.
REQ-032 The block SHALL instantiate the existing full_adder (i_a, i_b, i_cin, o_sum, o_cout) exactly once as its only sub-module; the datapath SHALL contain no other adders.

Verification (WIDTH=8)
REQ-033 Bench scenario, basic add: A=0x0F, B=0x01, cin=0 -> o_sum=0x10, o_cout=0, o_done in the cycle after edge E+8, o_busy high in between.
REQ-034 Bench scenario, carry-out and carry-in: A=0xFF, B=0x01, cin=0 -> 0x00, o_cout=1; then A=0xFF, B=0x00, cin=1 -> 0x00, o_cout=1.
REQ-035 Bench scenario, overflow (macro defined): A=0x7F, B=0x01 -> o_sum=0x80, o_ovf=1; A=0x80, B=0x80 -> o_sum=0x00, o_cout=1, o_ovf=1; A=0x40, B=0x10 -> o_ovf=0.
REQ-036 Bench scenario, start while busy: accept 0x12+0x34, then pulse i_start with 0xFF/0xFF at bit 3 and in DONE -> single o_done, o_sum=0x46.
REQ-037 Bench scenario, reset mid-RUN: assert i_rst after 4 RUN edges -> all outputs 0, no o_done; the next start with 0x05+0x03 -> o_sum=0x08 at nominal latency.
REQ-038 Bench scenario, back-to-back: hold i_start high continuously -> accepts spaced WIDTH+2=10 cycles apart, each result correct.

Source files
------------

// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM state encoding
// and the default operand width.
package serial_adder_pkg;

  localparam int SA_WIDTH_DEFAULT = 8;

  typedef logic [1:0] sa_state_t;

  localparam sa_state_t ST_IDLE = 2'd0;
  localparam sa_state_t ST_RUN  = 2'd1;
  localparam sa_state_t ST_DONE = 2'd2;

endpackage

// File: rtl/serial_adder_ctrl_if.sv
// Request/result bundle of the bit-serial adder controller.
// o_ovf exists only when SERIAL_ADDER_OVF_EN is defined.
interface serial_adder_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             i_start;
  logic [WIDTH-1:0] i_a;
  logic [WIDTH-1:0] i_b;
  logic             i_cin;
  logic             o_busy;
  logic             o_done;
  logic [WIDTH-1:0] o_sum;
  logic             o_cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic             o_ovf;

  modport master (output i_start, i_a, i_b, i_cin,
                  input  o_busy, o_done, o_sum, o_cout, o_ovf);
  modport slave  (input  i_start, i_a, i_b, i_cin,
                  output o_busy, o_done, o_sum, o_cout, o_ovf);
`else
  modport master (output i_start, i_a, i_b, i_cin,
                  input  o_busy, o_done, o_sum, o_cout);
  modport slave  (input  i_start, i_a, i_b, i_cin,
                  output o_busy, o_done, o_sum, o_cout);
`endif
endinterface

// File: rtl/serial_adder_ctrl_full_adder.sv
// Single-bit full-adder cell; the only arithmetic element of the serial adder.
module full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_sum,
  output logic o_cout
);

  assign o_sum  = i_a ^ i_b ^ i_cin;
  assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full-adder cell, LSB first, one bit per clock.
// Optional signed-overflow output enabled by SERIAL_ADDER_OVF_EN.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = SA_WIDTH_DEFAULT
) (
  input  logic               i_clk,
  input  logic               i_rst,
  serial_adder_ctrl_if.slave bus
);

  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  sa_state_t        state_r;
  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  logic             carry_r;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] sum_r;
  logic             cout_r;
  logic             busy_r;
  logic             done_r;
  logic             fa_sum_s;
  logic             fa_cout_s;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_r;
`endif

  full_adder u_fa (
    .i_a    (a_sh_r[0]),
    .i_b    (b_sh_r[0]),
    .i_cin  (carry_r),
    .o_sum  (fa_sum_s),
    .o_cout (fa_cout_s)
  );

  // Control FSM with the serial datapath; the counter stops at WIDTH-1 so it never wraps.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r <= ST_IDLE;
      a_sh_r  <= {WIDTH{1'b0}};
      b_sh_r  <= {WIDTH{1'b0}};
      carry_r <= 1'b0;
      cnt_r   <= {CW{1'b0}};
      sum_r   <= {WIDTH{1'b0}};
      cout_r  <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_r   <= 1'b0;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.i_start) begin
            a_sh_r  <= bus.i_a;
            b_sh_r  <= bus.i_b;
            carry_r <= bus.i_cin;
            cnt_r   <= {CW{1'b0}};
            sum_r   <= {WIDTH{1'b0}};
            cout_r  <= 1'b0;
            busy_r  <= 1'b1;
            state_r <= ST_RUN;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_r   <= 1'b0;
`endif
          end
        end
        ST_RUN: begin
          sum_r   <= {fa_sum_s, sum_r[WIDTH-1:1]};
          a_sh_r  <= {1'b0, a_sh_r[WIDTH-1:1]};
          b_sh_r  <= {1'b0, b_sh_r[WIDTH-1:1]};
          carry_r <= fa_cout_s;
          if (cnt_r == CNT_LAST) begin
            cout_r  <= fa_cout_s;
            done_r  <= 1'b1;
            state_r <= ST_DONE;
`ifdef SERIAL_ADDER_OVF_EN
            // carry_r here is the carry into the MSB
            ovf_r   <= carry_r ^ fa_cout_s;
`endif
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        ST_DONE: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.o_busy = busy_r;
  assign bus.o_done = done_r;
  assign bus.o_sum  = sum_r;
  assign bus.o_cout = cout_r;
`ifdef SERIAL_ADDER_OVF_EN
  assign bus.o_ovf  = ovf_r;
`endif

endmodule
